// File: rtl/piso_pkg_amisha.sv
// Shared definitions for the PISO shift transmitter: state encoding and
// the bit-counter width helper.
package piso_pkg_amisha;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_e;

  // Wide enough to hold 0..nbits so the counter can never wrap inside a frame.
  function automatic int cnt_width(input int nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/bit_counter_amisha.sv
// Synchronous-clear, enabled up-counter that saturates at MAX and flags
// the terminal count (used as the last-bit indicator of a frame).
module bit_counter_amisha
  import piso_pkg_amisha::*;
#(
  parameter int MAX = 7
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = cnt_width(MAX + 1);
  localparam logic [CW-1:0] TC = CW'(MAX);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TC)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == TC);

endmodule

// File: rtl/piso_shift_tx_amisha.sv
// Parallel-in serial-out transmitter, LSB first, with frame and done pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_shift_tx_amisha
  import piso_pkg_amisha::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_amisha,
  input  logic             reset_amisha,
  input  logic             load_amisha,
  input  logic [WIDTH-1:0] din_amisha,
  output logic             ready_amisha,
  output logic             sout_amisha,
  output logic             frame_amisha,
  output logic             done_tick_amisha
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  state_e           state;
  state_e           state_nx;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] load_word;
  logic             last;
  logic             in_shift;

`ifdef PISO_PARITY_EN
  assign load_word = {^din_amisha, din_amisha};
`else
  assign load_word = din_amisha;
`endif

  assign in_shift = (state == S_SHIFT);

  // Counter is held clear whenever idle so each frame starts from bit 0.
  bit_counter_amisha #(
    .MAX(NBITS - 1)
  ) u_bit_counter (
    .clk (clk_amisha),
    .clr (reset_amisha || !in_shift),
    .en  (in_shift),
    .last(last)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (load_amisha) state_nx = S_SHIFT;
      S_SHIFT: if (last)        state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state <= S_IDLE;
      shreg <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && load_amisha) begin
        shreg <= load_word;
      end else if (in_shift) begin
        shreg <= shreg >> 1;
      end
    end
  end

  // Outputs depend only on state and registers, never on load/din.
  assign ready_amisha     = (state == S_IDLE);
  assign frame_amisha     = in_shift;
  assign sout_amisha      = in_shift & shreg[0];
  assign done_tick_amisha = in_shift & last;

endmodule
